s_machine_arbiter: RTL and testbench

Round-robin scheduler that shares the single start/done execution unit of the S-Machine CPU among up to NUM_REQ requesters. Grants one requester at a time, issues a one-cycle start pulse to the unit, waits for done, and returns a one-cycle ack to the granted requester. Keeps a wrapping count of completed operations. Sits between the requester front-ends and the execution unit's start/done handshake.

---
 rtl/s_machine_pkg.sv | 26 ++
 rtl/s_machine_arbiter_rr_pick.sv | 47 ++++
 rtl/s_machine_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_s_machine_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/s_machine_pkg.sv
// -----------------------------------------------------------------------------
// s_machine_pkg
// Shared types and constants for the S-Machine shared-unit arbiters.
//   state_t      : arbiter FSM state (IDLE, ISSUE, WAIT)
//   DEF_NUM_REQ  : default requester count
//   DEF_CNT_W    : default completed-operation counter width
//   DEF_PTR_W    : round-robin pointer width for DEF_NUM_REQ
//   ptr_width()  : pointer width for any requester count (never below 1)
// -----------------------------------------------------------------------------
package s_machine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_PTR_W   = $clog2(DEF_NUM_REQ);

   function automatic int ptr_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/s_machine_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches upward from i_ptr for the first
// set request, wrapping to the lowest index.
//   i_req    [NUM_REQ] : request vector
//   i_ptr    [PTR_W]   : highest-priority index this round
//   o_onehot [NUM_REQ] : one-hot winner (0 when nothing requested)
//   o_valid            : at least one request set
//   o_idx    [PTR_W]   : binary index of the winner
// -----------------------------------------------------------------------------
module rr_pick
   import s_machine_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic               o_valid,
   output logic [PTR_W-1:0]   o_idx
);

   always_comb begin : pick
      logic [PTR_W-1:0] w_j;
      logic             w_found;
      // NOTE: every output and local gets a default first, so no path through
      // the block leaves a value unassigned and no latch is inferred.
      o_onehot = '0;
      o_valid  = 1'b0;
      o_idx    = '0;
      w_found  = 1'b0;
      w_j      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Candidate index rotates from the pointer and wraps modulo NUM_REQ,
         // which also covers non-power-of-two requester counts.
         w_j = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
         if (!w_found && i_req[w_j]) begin
            w_found       = 1'b1;
            o_valid       = 1'b1;
            o_onehot[w_j] = 1'b1;
            o_idx         = w_j;
         end
      end
   end

endmodule

// File: rtl/s_machine_arbiter.sv
// -----------------------------------------------------------------------------
// s_machine_arbiter
// Round-robin scheduler sharing the S-Machine start/done execution unit among
// NUM_REQ requesters. One grant at a time: IDLE -> ISSUE (start pulse) ->
// WAIT (until done) -> IDLE with a one-cycle ack. All outputs registered.
//
// Optional feature macro: S_MACHINE_ARB_TIMEOUT_EN
//   When defined, a watchdog aborts a WAIT lasting TIMEOUT cycles without
//   done (timeout pulse, no ack, count unchanged). When undefined, WAIT holds
//   indefinitely and o_timeout is tied low.
//
// Ports:
//   clk                 : clock, all state on rising edge
//   rst_n               : asynchronous active-low reset
//   i_enable            : permits new grants; never aborts an operation
//   i_req     [NUM_REQ] : level requests, held until ack
//   o_grant   [NUM_REQ] : one-hot grant, high from ISSUE through WAIT
//   o_start             : one-cycle start pulse to the execution unit
//   i_done              : completion from the unit, sampled only in WAIT
//   o_ack     [NUM_REQ] : one-cycle one-hot ack on completion
//   o_busy              : state is not IDLE
//   o_count   [CNT_W]   : completed operations, wraps modulo 2^CNT_W
//   o_timeout           : one-cycle watchdog abort pulse
// -----------------------------------------------------------------------------
module s_machine_arbiter
   import s_machine_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_enable,
   input  logic [NUM_REQ-1:0] i_req,
   output logic [NUM_REQ-1:0] o_grant,
   output logic               o_start,
   input  logic               i_done,
   output logic [NUM_REQ-1:0] o_ack,
   output logic               o_busy,
   output logic [CNT_W-1:0]   o_count,
   output logic               o_timeout
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
   logic [NUM_REQ-1:0] r_ack,     w_ack_nxt;
   logic               r_start,   w_start_nxt;
   logic               r_busy,    w_busy_nxt;
   logic               r_timeout, w_timeout_nxt;
   logic [CNT_W-1:0]   r_count,   w_count_nxt;
   logic [PTR_W-1:0]   r_ptr,     w_ptr_nxt;
   logic [PTR_W-1:0]   r_idx,     w_idx_nxt;

   logic [NUM_REQ-1:0] w_win_onehot;
   logic               w_win_valid;
   logic [PTR_W-1:0]   w_win_idx;
   logic               w_go;
   logic [PTR_W-1:0]   w_ptr_after;
   logic               w_abort;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_onehot (w_win_onehot),
      .o_valid  (w_win_valid),
      .o_idx    (w_win_idx)
   );

   assign w_go = (r_state == IDLE) && i_enable && w_win_valid;

   // Priority moves to the requester just past the current winner, so a
   // continuously requesting winner cannot starve the others.
   assign w_ptr_after = (r_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_idx + PTR_W'(1);

`ifdef S_MACHINE_ARB_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   logic [WDOG_W-1:0] r_wdog, w_wdog_nxt, w_wdog_inc;

   assign w_wdog_inc = r_wdog + WDOG_W'(1);

   // Abort on the WAIT cycle whose increment would reach the limit; done in
   // that same cycle takes precedence because it is checked here too.
   assign w_abort = (r_state == WAIT) && !i_done && (w_wdog_inc == WDOG_W'(TIMEOUT));

   always_comb begin
      w_wdog_nxt = r_wdog;
      if (r_state == ISSUE) begin
         w_wdog_nxt = '0;
      end else if ((r_state == WAIT) && !i_done) begin
         w_wdog_nxt = w_wdog_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog <= '0;
      end else begin
         r_wdog <= w_wdog_nxt;
      end
   end
`else
   assign w_abort = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         // NOTE: non-blocking assignments so every register in the design
         // samples pre-edge values regardless of process ordering.
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_go) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = WAIT;
         WAIT:    if (i_done || w_abort) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output logic: computes next values of the registered outputs.
   always_comb begin
      w_grant_nxt   = r_grant;
      w_idx_nxt     = r_idx;
      w_ptr_nxt     = r_ptr;
      w_count_nxt   = r_count;
      w_start_nxt   = 1'b0;
      w_ack_nxt     = '0;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_go) begin
               w_grant_nxt = w_win_onehot;
               w_idx_nxt   = w_win_idx;
               w_start_nxt = 1'b1;
            end
         end
         WAIT: begin
            if (i_done) begin
               w_ack_nxt   = r_grant;
               w_count_nxt = r_count + CNT_W'(1);
               w_ptr_nxt   = w_ptr_after;
               w_grant_nxt = '0;
            end else if (w_abort) begin
               w_timeout_nxt = 1'b1;
               w_ptr_nxt     = w_ptr_after;
               w_grant_nxt   = '0;
            end
         end
         default: ;
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant   <= '0;
         r_idx     <= '0;
         r_ptr     <= '0;
         r_count   <= '0;
         r_start   <= 1'b0;
         r_ack     <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_grant   <= w_grant_nxt;
         r_idx     <= w_idx_nxt;
         r_ptr     <= w_ptr_nxt;
         r_count   <= w_count_nxt;
         r_start   <= w_start_nxt;
         r_ack     <= w_ack_nxt;
         r_busy    <= w_busy_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign o_grant   = r_grant;
   assign o_start   = r_start;
   assign o_ack     = r_ack;
   assign o_busy    = r_busy;
   assign o_count   = r_count;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_s_machine_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s_machine_arbiter
// Directed bench for s_machine_arbiter (NUM_REQ=4, CNT_W=8, TIMEOUT=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// The watchdog scenario runs only when S_MACHINE_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_s_machine_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 4;

   logic               clk;
   logic               rst_n;
   logic               enable;
   logic               done;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] ack;
   logic               start;
   logic               busy;
   logic [CNT_W-1:0]   count;
   logic               timeout;

   int               n_checks = 0;
   int               n_pass   = 0;
   logic [CNT_W-1:0] exp_count;
   logic             seen_timeout = 1'b0;

   s_machine_arbiter #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_enable  (enable),
      .i_req     (req),
      .o_grant   (grant),
      .o_start   (start),
      .i_done    (done),
      .o_ack     (ack),
      .o_busy    (busy),
      .o_count   (count),
      .o_timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (timeout === 1'b1) seen_timeout <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_grant"}, 32'(grant), 32'h0);
      check({tag, "_start"}, 32'(start), 32'h0);
      check({tag, "_ack"},   32'(ack),   32'h0);
      check({tag, "_busy"},  32'(busy),  32'h0);
   endtask

   // Caller has set enable/req so IDLE grants on the next edge. done is raised
   // after extra_wait WAIT cycles without it.
   task automatic run_op(input logic [NUM_REQ-1:0] exp_grant, input int extra_wait);
      tick();
      check("issue_grant", 32'(grant), 32'(exp_grant));
      check("issue_start", 32'(start), 32'h1);
      check("issue_busy",  32'(busy),  32'h1);
      check("issue_ack",   32'(ack),   32'h0);
      tick();
      check("wait_start", 32'(start), 32'h0);
      check("wait_grant", 32'(grant), 32'(exp_grant));
      for (int i = 0; i < extra_wait; i++) begin
         tick();
         check("hold_grant", 32'(grant), 32'(exp_grant));
         check("hold_ack",   32'(ack),   32'h0);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      exp_count = exp_count + CNT_W'(1);
      check("done_ack",   32'(ack),   32'(exp_grant));
      check("done_grant", 32'(grant), 32'h0);
      check("done_start", 32'(start), 32'h0);
      check("done_busy",  32'(busy),  32'h0);
      check("done_count", 32'(count), 32'(exp_count));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b0;
      req       = '0;
      done      = 1'b0;
      exp_count = '0;

      // Reset state
      tick();
      tick();
      check_quiet("rst");
      check("rst_count",   32'(count),   32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      rst_n = 1'b1;
      tick();
      check_quiet("post_rst");

      // Single requester, done two cycles after start
      enable = 1'b1;
      req    = 4'b0100;
      run_op(4'b0100, 1);
      req = '0;
      tick();
      check("single_ack_pulse", 32'(ack),   32'h0);
      check("single_idle_busy", 32'(busy),  32'h0);
      check("single_count",     32'(count), 32'h1);

      // Reset asserted mid-WAIT clears everything, including the pointer
      req = 4'b0010;
      tick();
      check("pre_rst_grant", 32'(grant), 32'h2);
      tick();
      check("pre_rst_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check_quiet("async_rst");
      check("async_rst_count", 32'(count), 32'h0);
      tick();
      check("rst_hold_count", 32'(count), 32'h0);
      rst_n     = 1'b1;
      exp_count = '0;
      // Pointer back at 0: requester 0 wins over requester 3
      req = 4'b1001;
      run_op(4'b0001, 0);
      req = '0;

      // Full rotation with all requesters active
      do_reset();
      req = 4'b1111;
      run_op(4'b0001, 0);
      run_op(4'b0010, 0);
      run_op(4'b0100, 0);
      run_op(4'b1000, 0);
      run_op(4'b0001, 0);
      req = '0;
      check("rot_count", 32'(count), 32'h5);

      // enable dropped mid-operation, requester drops while granted
      req = 4'b0010;
      tick();
      check("en_issue_grant", 32'(grant), 32'h2);
      tick();
      enable = 1'b0;
      req    = '0;
      tick();
      check("en_wait_grant", 32'(grant), 32'h2);
      check("en_wait_busy",  32'(busy),  32'h1);
      done = 1'b1;
      tick();
      done      = 1'b0;
      exp_count = exp_count + CNT_W'(1);
      check("en_ack",   32'(ack),   32'h2);
      check("en_count", 32'(count), 32'(exp_count));
      req = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("en_blocked_grant", 32'(grant), 32'h0);
         check("en_blocked_busy",  32'(busy),  32'h0);
      end
      // done in IDLE is ignored
      done = 1'b1;
      tick();
      done = 1'b0;
      check("idle_done_ack",   32'(ack),   32'h0);
      check("idle_done_count", 32'(count), 32'(exp_count));
      enable = 1'b1;
      run_op(4'b0001, 0);
      req = '0;
      check("pre_wrap_count", 32'(count), 32'h7);

      // Counter wrap: back-to-back 3-cycle operations up to 255, then one more
      req  = 4'b0001;
      done = 1'b1;
      repeat (3 * (255 - 7)) tick();
      check("wrap_count_255", 32'(count), 32'hff);
      check("wrap_ack_255",   32'(ack),   32'h1);
      repeat (3) tick();
      check("wrap_count_0", 32'(count), 32'h0);
      check("wrap_ack_0",   32'(ack),   32'h1);
      done = 1'b0;
      req  = '0;
      tick();
      check_quiet("wrap_idle");

`ifdef S_MACHINE_ARB_TIMEOUT_EN
      // Watchdog: done never arrives
      do_reset();
      req = 4'b0011;
      tick();
      check("wd_issue_grant", 32'(grant), 32'h1);
      for (int i = 0; i < TIMEOUT; i++) begin
         tick();
         check("wd_wait_grant",   32'(grant),   32'h1);
         check("wd_wait_timeout", 32'(timeout), 32'h0);
      end
      tick();
      check("wd_timeout", 32'(timeout), 32'h1);
      check("wd_ack",     32'(ack),     32'h0);
      check("wd_grant",   32'(grant),   32'h0);
      check("wd_count",   32'(count),   32'h0);
      check("wd_busy",    32'(busy),    32'h0);
      tick();
      check("wd_next_grant",   32'(grant),   32'h2);
      check("wd_timeout_pulse", 32'(timeout), 32'h0);
      req = '0;
`else
      check("no_timeout_ever", 32'(seen_timeout), 32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
